// File: rtl/pipe_pkg.sv
// Shared pipeline types for the unified memory port arbiter.
package pipe_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/arb_perf_counter.sv
// 32-bit saturating event counter with synchronous clear.
module arb_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetches and MEM loads/stores.
// Define ARB_PERF_CNT_EN to add the stall-cycle performance counters.
module mem_port_arbiter
    import pipe_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ready,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_be,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
    output logic            stall_mem
`ifdef ARB_PERF_CNT_EN
    ,
    input  logic            perf_clr,
    output logic [31:0]     perf_if_wait,
    output logic [31:0]     perf_dm_wait
`endif
);

    arb_state_t      state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            last_dm_q, last_dm_d;
    logic            abandon_q, abandon_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0] mem_be_q, mem_be_d;
    logic            pick_dm;
    logic            rsp;

    assign rsp = (state_q == WAIT) && mem_rvalid;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_dm_d   = last_dm_q;
        abandon_d   = abandon_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        // Alternate on contention; a lone requester always wins.
        pick_dm     = dm_req && !(if_req && last_dm_q);
        unique case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d     = ISSUE;
                    owner_d     = pick_dm ? OWN_DM : OWN_IF;
                    last_dm_d   = pick_dm;
                    abandon_d   = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_dm && dm_we;
                    mem_addr_d  = pick_dm ? dm_addr : if_addr;
                    mem_wdata_d = pick_dm ? dm_wdata : '0;
                    mem_be_d    = pick_dm ? dm_be : '1;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A flushed fetch still drains on the memory side, silently.
        if ((state_q != IDLE) && (owner_q == OWN_IF) && !if_req) begin
            abandon_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_dm_q   <= 1'b0;
            abandon_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_dm_q   <= last_dm_d;
            abandon_q   <= abandon_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign if_ready  = rsp && (owner_q == OWN_IF) && if_req && !abandon_q;
    assign dm_ready  = rsp && (owner_q == OWN_DM);
    assign stall_if  = if_req && !if_ready;
    assign stall_mem = dm_req && !dm_ready;

`ifdef ARB_PERF_CNT_EN
    arb_perf_counter #(.W(32)) u_if_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (stall_if),
        .count (perf_if_wait)
    );

    arb_perf_counter #(.W(32)) u_dm_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (stall_mem),
        .count (perf_dm_wait)
    );
`endif

endmodule
